// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: FSM state encoding and default sizing.
package freq_meter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GATE = 1'b1;

  // One second at 100 MHz; 28 bits holds any count up to that rate.
  localparam int unsigned DEF_GATE_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W       = 28;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A 0->1 on async_in yields a one-cycle rise_pulse three clk_in cycles later.
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q;
  logic sync_q;
  logic sync_d;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // so the chain really is three stages deep rather than collapsing into one.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_d     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      meta_q     <= async_in;
      sync_q     <= meta_q;
      sync_d     <= sync_q;
      rise_pulse <= sync_q & ~sync_d;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clk_in
// cycles, single-shot on start or back-to-back while cont is high.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             ovf
);

  localparam int unsigned      GW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    LAST     = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             rise_pulse;
  logic [0:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             win_ovf;
  logic             ovf_nxt;
  logic             last_cycle;

  sync_edge u_sync_edge (
    .clk_in     (clk_in),
    .rst        (rst),
    .async_in   (sig_in),
    .rise_pulse (rise_pulse)
  );

  // NOTE: both outputs get a default before the if, so no latch is inferred.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = win_ovf;
    if (rise_pulse) begin
      if (edge_cnt == CNT_MAX) ovf_nxt  = 1'b1;
      else                     edge_nxt = edge_cnt + 1'b1;
    end
  end

  assign last_cycle = (gate_cnt == LAST);
  assign busy       = (state == ST_GATE);

  // edge_nxt already folds in the final cycle's pulse, so the result register
  // captures it directly without an extra cycle of latency.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      win_ovf  <= 1'b0;
      done     <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start || cont) begin
          state    <= ST_GATE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          win_ovf  <= 1'b0;
        end
      end else if (last_cycle) begin
        freq     <= edge_nxt;
        ovf      <= ovf_nxt;
        done     <= 1'b1;
        state    <= cont ? ST_GATE : ST_IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
        win_ovf  <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_nxt;
        win_ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100_000_000, number of clk_in cycles in one measurement window (1 s at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 28, width of the edge counter and result.
REQ-003 SHALL have port clk_in, input, 1, system clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1, external signal to measure, asynchronous to clk_in.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin one measurement.
REQ-007 SHALL have port cont, input, 1, when high, windows restart back-to-back with no start needed.
REQ-008 SHALL have port busy, output, 1, high while a window is open.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when freq and ovf update.
REQ-010 SHALL have port freq, output, CNT_W, rising edges counted in the last completed window.
REQ-011 SHALL have port ovf, output, 1, the last completed window saturated the counter.

Function
REQ-012 SHALL pass sig_in through a two-flop synchronizer, then a rising-edge detector producing a one-cycle edge pulse when the synchronized value goes 0 to 1; total latency 3 cycles from sig_in to pulse.
REQ-013 SHALL implement states IDLE and GATE; busy = (state == GATE).
REQ-014 SHALL move IDLE -> GATE on the cycle after start = 1 or cont = 1 is sampled, clearing the gate and edge counters.
REQ-015 SHALL increment the gate counter once per cycle in GATE, from 0 to GATE_CYCLES-1.
REQ-016 SHALL count exactly the edge pulses present on cycles where state == GATE, including the final gate cycle.
REQ-017 SHALL saturate the edge counter at 2^CNT_W-1, never wrap, and record a sticky overflow flag for the window.
REQ-018 SHALL, on the cycle after the final gate cycle (gate counter == GATE_CYCLES-1), load freq with the final count, load ovf with the window flag, and pulse done for exactly one cycle.
REQ-019 SHALL, on that final gate cycle, go to GATE with cleared counters if cont = 1, otherwise to IDLE; no cycle is lost between continuous windows.
REQ-020 SHALL ignore start while in GATE.
REQ-021 SHALL hold freq and ovf stable between done pulses.
REQ-022 SHALL let cont falling mid-window finish the current window, then return to IDLE.
REQ-023 SHALL let an edge pulse on the final gate cycle count in the closing window, and an edge pulse on the first cycle of the next window count in the new window.

Reset
REQ-024 SHALL, while rst = 1, asynchronously force state = IDLE, all counters = 0, synchronizer and edge flops = 0, busy = 0, done = 0, freq = 0, ovf = 0.
REQ-025 SHALL, on reset mid-window, discard the partial count without producing done; the next window starts only on a new start or cont.

Structure
REQ-026 SHALL place the state encoding (IDLE, GATE) and the default GATE_CYCLES/CNT_W constants in the shared lab package.
REQ-027 SHALL implement the synchronizer and edge detector as one sub-module, sync_edge (inputs clk_in, rst, async_in; output rise_pulse).
REQ-028 SHALL size the gate counter as clog2(GATE_CYCLES) bits, and use a 1-bit state register plus CNT_W-bit edge counter and result registers.

Verification (GATE_CYCLES = 100, CNT_W = 8 unless noted)
REQ-029 SHALL check reset: after rst is released, freq = 0, ovf = 0, busy = 0, and done never pulses without start.
REQ-030 SHALL check a single window: sig_in period 10 cycles, start pulse -> busy high 100 cycles, one done pulse, freq = 10, ovf = 0, then busy = 0.
REQ-031 SHALL check continuous mode: cont = 1, sig_in period 4 -> done every 100 cycles exactly, each freq = 25, busy never drops.
REQ-032 SHALL check overflow: CNT_W = 4, sig_in period 2 (50 edges) -> freq = 15, ovf = 1; the next window at period 20 -> freq = 5, ovf = 0.
REQ-033 SHALL check robustness: start re-pulsed at gate cycle 50 is ignored (done at cycle 100 only), and rst asserted at gate cycle 60 gives no done, freq = 0, busy = 0.
REQ-034 SHALL check a static input: sig_in held high for a whole window -> freq = 0, and a single 0->1 edge -> freq = 1.
